// File: rtl/ad_smp_ctrl_if.sv
// Sample result port of ad_smp_ctrl: valid/ready result handoff plus overrun status.
// Optional AD_OVR_CNT_EN adds the 16-bit overrun counter.
interface ad_smp_ctrl_if #(
    parameter int DATA_BITS = 12
);
    // Valid/ready: a result transfers on a cycle where smp_vld & smp_rdy; smp_data is stable
    // while smp_vld is high unless a newer result overwrites it (reported through smp_ovr).
    logic [DATA_BITS-1:0] smp_data;
    logic                 smp_vld;
    logic                 smp_rdy;
    logic                 smp_ovr;
`ifdef AD_OVR_CNT_EN
    logic [15:0]          ovr_cnt;
`endif

    modport master (
        output smp_data, smp_vld, smp_ovr,
`ifdef AD_OVR_CNT_EN
        output ovr_cnt,
`endif
        input  smp_rdy
    );

    modport slave (
        input  smp_data, smp_vld, smp_ovr,
`ifdef AD_OVR_CNT_EN
        input  ovr_cnt,
`endif
        output smp_rdy
    );
endinterface

// File: rtl/ad_smp_ctrl.sv
// Serial ADC sampling scheduler: periodic cs_n/sclk frames, burst/continuous modes, result handoff.
// Define AD_OVR_CNT_EN to add the saturating overrun counter on the result interface.
module ad_smp_ctrl #(
    parameter int SCLK_DIV   = 2,
    parameter int FRAME_BITS = 16,
    parameter int DATA_BITS  = 12,
    parameter int QUIET_CYC  = 4
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        cfg_en,
    input  logic [15:0] cfg_period,
    input  logic [15:0] cfg_num,
    input  logic        cmd_start,
    input  logic        cmd_stop,
    output logic        busy,
    output logic        done,
    output logic        ad_cs_n,
    output logic        ad_sclk,
    input  logic        ad_sdata,
    ad_smp_ctrl_if.master smp,
    output logic [1:0]  dbg_state
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CONV  = 2'd1;
    localparam logic [1:0] S_QUIET = 2'd2;
    localparam logic [1:0] S_WAIT  = 2'd3;

    localparam logic [7:0] DIV_LAST   = 8'(SCLK_DIV - 1);
    localparam logic [7:0] HALF_LAST  = 8'(2 * FRAME_BITS - 1);
    localparam logic [7:0] QUIET_LAST = 8'(QUIET_CYC - 1);
    localparam int         LEAD       = 2;

    logic [1:0]           state_q, state_d;
    logic [7:0]           div_q, div_d;
    logic [7:0]           half_q, half_d;
    logic [7:0]           quiet_q, quiet_d;
    logic                 cs_n_q, cs_n_d;
    logic                 sclk_q, sclk_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic [15:0]          per_q, per_d;
    logic [15:0]          period_q, period_d;
    logic [15:0]          num_q, num_d;
    logic [15:0]          smp_cnt_q, smp_cnt_d;
    logic                 stop_q, stop_d;
    logic                 done_q, done_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 vld_q, vld_d;
    logic                 ovr_q, ovr_d;
`ifdef AD_OVR_CNT_EN
    logic [15:0]          ovr_cnt_q, ovr_cnt_d;
`endif
    logic                 stop_req;
    logic                 load;
    logic                 finish;
    logic                 enter_conv;
    logic                 burst_end;

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        half_d     = half_q;
        quiet_d    = quiet_q;
        cs_n_d     = cs_n_q;
        sclk_d     = sclk_q;
        sh_d       = sh_q;
        per_d      = (per_q == 16'hFFFF) ? per_q : per_q + 16'd1;
        period_d   = period_q;
        num_d      = num_q;
        smp_cnt_d  = smp_cnt_q;
        stop_d     = stop_q;
        done_d     = 1'b0;
        data_d     = data_q;
        vld_d      = vld_q;
        ovr_d      = ovr_q;
`ifdef AD_OVR_CNT_EN
        ovr_cnt_d  = ovr_cnt_q;
`endif
        stop_req   = cmd_stop | ~cfg_en;
        load       = 1'b0;
        finish     = 1'b0;
        enter_conv = 1'b0;
        burst_end  = 1'b0;

        if (state_q != S_IDLE && stop_req) stop_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (cmd_start && cfg_en && !cmd_stop) begin
                    period_d   = cfg_period;
                    num_d      = cfg_num;
                    smp_cnt_d  = 16'd0;
                    stop_d     = 1'b0;
                    ovr_d      = 1'b0;
`ifdef AD_OVR_CNT_EN
                    ovr_cnt_d  = 16'd0;
`endif
                    enter_conv = 1'b1;
                end
            end
            S_CONV: begin
                if (div_q == DIV_LAST) begin
                    div_d  = 8'd0;
                    sclk_d = ~sclk_q;
                    // Rising sclk edge k carries frame bit FRAME_BITS-1-k; keep only the result field.
                    if (!sclk_q && half_q[7:1] >= 7'(LEAD) && half_q[7:1] < 7'(LEAD + DATA_BITS))
                        sh_d = {sh_q[DATA_BITS-2:0], ad_sdata};
                    if (half_q == HALF_LAST) begin
                        state_d = S_QUIET;
                        quiet_d = 8'd0;
                        cs_n_d  = 1'b1;
                        sclk_d  = 1'b1;
                    end else begin
                        half_d = half_q + 8'd1;
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            S_QUIET: begin
                if (quiet_q == 8'd0) begin
                    load      = 1'b1;
                    smp_cnt_d = smp_cnt_q + 16'd1;
                end
                if (quiet_q == QUIET_LAST) begin
                    burst_end = stop_q | stop_req | ((num_q != 16'd0) && (smp_cnt_d == num_q));
                    if (burst_end)               finish     = 1'b1;
                    else if (per_q >= period_q)  enter_conv = 1'b1;
                    else                         state_d    = S_WAIT;
                end else begin
                    quiet_d = quiet_q + 8'd1;
                end
            end
            default: begin
                if (stop_q || stop_req)      finish     = 1'b1;
                else if (per_q >= period_q)  enter_conv = 1'b1;
            end
        endcase

        // The period counter restarts on every cs_n falling edge.
        if (enter_conv) begin
            state_d = S_CONV;
            cs_n_d  = 1'b0;
            sclk_d  = 1'b0;
            div_d   = 8'd0;
            half_d  = 8'd0;
            per_d   = 16'd1;
        end
        if (finish) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
        end

        if (load) begin
            data_d = sh_q;
            vld_d  = 1'b1;
            if (vld_q && !smp.smp_rdy) begin
                ovr_d = 1'b1;
`ifdef AD_OVR_CNT_EN
                if (ovr_cnt_q != 16'hFFFF) ovr_cnt_d = ovr_cnt_q + 16'd1;
`endif
            end
        end else if (vld_q && smp.smp_rdy) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            div_q     <= 8'd0;
            half_q    <= 8'd0;
            quiet_q   <= 8'd0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b1;
            sh_q      <= '0;
            per_q     <= 16'd0;
            period_q  <= 16'd0;
            num_q     <= 16'd0;
            smp_cnt_q <= 16'd0;
            stop_q    <= 1'b0;
            done_q    <= 1'b0;
            data_q    <= '0;
            vld_q     <= 1'b0;
            ovr_q     <= 1'b0;
`ifdef AD_OVR_CNT_EN
            ovr_cnt_q <= 16'd0;
`endif
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            half_q    <= half_d;
            quiet_q   <= quiet_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            sh_q      <= sh_d;
            per_q     <= per_d;
            period_q  <= period_d;
            num_q     <= num_d;
            smp_cnt_q <= smp_cnt_d;
            stop_q    <= stop_d;
            done_q    <= done_d;
            data_q    <= data_d;
            vld_q     <= vld_d;
            ovr_q     <= ovr_d;
`ifdef AD_OVR_CNT_EN
            ovr_cnt_q <= ovr_cnt_d;
`endif
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;
    assign ad_cs_n      = cs_n_q;
    assign ad_sclk      = sclk_q;
    assign dbg_state    = state_q;
    assign smp.smp_data = data_q;
    assign smp.smp_vld  = vld_q;
    assign smp.smp_ovr  = ovr_q;
`ifdef AD_OVR_CNT_EN
    assign smp.ovr_cnt  = ovr_cnt_q;
`endif
endmodule

// File: tb/tb_ad_smp_ctrl.sv
// Directed bench for ad_smp_ctrl: table of burst vectors plus hand sequences for
// overrun, stop mid-frame, async reset mid-frame and start/stop collisions.
module tb_ad_smp_ctrl;
    logic        clk_sys = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_en = 1'b1;
    logic [15:0] cfg_period = 16'd0;
    logic [15:0] cfg_num = 16'd0;
    logic        cmd_start = 1'b0;
    logic        cmd_stop = 1'b0;
    logic        busy, done, ad_cs_n, ad_sclk;
    logic        ad_sdata = 1'b0;
    logic [1:0]  dbg_state;

    ad_smp_ctrl_if #(.DATA_BITS(12)) smp_if ();

    ad_smp_ctrl dut (
        .clk_sys(clk_sys), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_period(cfg_period),
        .cfg_num(cfg_num), .cmd_start(cmd_start), .cmd_stop(cmd_stop), .busy(busy),
        .done(done), .ad_cs_n(ad_cs_n), .ad_sclk(ad_sclk), .ad_sdata(ad_sdata),
        .smp(smp_if), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk_sys = ~clk_sys;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ADC model: frame words queued by the test, shifted out MSB first, advancing after each sclk rise
    logic [15:0] adc_q[$];
    logic [15:0] frame = 16'd0;
    int          bit_idx = 0;
    always @(negedge ad_cs_n) begin
        frame   = (adc_q.size() > 0) ? adc_q.pop_front() : 16'd0;
        bit_idx = 15;
        ad_sdata = frame[15];
    end
    always @(posedge ad_sclk) begin
        if (!ad_cs_n && bit_idx > 0) begin
            bit_idx--;
            ad_sdata = frame[bit_idx];
        end
    end

    // scoreboard and monitor
    logic [11:0] exp_q[$];
    int          fall_q[$];
    int          rise_q[$];
    int          done_cnt = 0;
    logic        cs_prev = 1'b1;
    always @(negedge clk_sys) begin
        if (rst_n) begin
            if (cs_prev && !ad_cs_n) fall_q.push_back(cyc);
            if (!cs_prev && ad_cs_n) rise_q.push_back(cyc);
            if (done) begin
                done_cnt++;
                chk("busy_at_done", {31'd0, busy}, 32'd0);
            end
            if (smp_if.smp_vld && smp_if.smp_rdy) begin
                if (exp_q.size() == 0) chk("unexpected_sample", {20'd0, smp_if.smp_data}, 32'hFFFF_FFFF);
                else                   chk("smp_data", {20'd0, smp_if.smp_data}, {20'd0, exp_q.pop_front()});
            end
        end
        cs_prev = ad_cs_n;
    end

    // driver tasks
    task automatic clear_mon();
        fall_q.delete();
        rise_q.delete();
        done_cnt = 0;
    endtask

    task automatic push_sample(input logic [11:0] d, input bit expect_accept);
        adc_q.push_back({2'b00, d, 2'b00});
        if (expect_accept) exp_q.push_back(d);
    endtask

    task automatic pulse_start();
        @(posedge clk_sys); #1 cmd_start = 1'b1;
        @(posedge clk_sys); #1 cmd_start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(posedge clk_sys); #1 cmd_stop = 1'b1;
        @(posedge clk_sys); #1 cmd_stop = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int c = 0;
        while (done_cnt == 0 && c < lim) begin
            @(posedge clk_sys);
            c++;
        end
        #1;
        if (done_cnt == 0) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_falls(input int n, input int lim);
        int c = 0;
        while (fall_q.size() < n && c < lim) begin
            @(posedge clk_sys);
            c++;
        end
        #1;
        if (fall_q.size() < n) chk("fall_timeout", fall_q.size(), n);
    endtask

    typedef struct {
        int          period;
        int          num;
        logic [11:0] d0, d1, d2;
        bit          restart;
        int          gap;
    } vec_t;

    vec_t vecs[5];

    task automatic set_vec(input int i, input int p, input int n, input logic [11:0] a,
                           input logic [11:0] b, input logic [11:0] c, input bit r, input int g);
        vecs[i].period = p; vecs[i].num = n;
        vecs[i].d0 = a; vecs[i].d1 = b; vecs[i].d2 = c;
        vecs[i].restart = r; vecs[i].gap = g;
    endtask

    initial begin
        logic [11:0] last;
        set_vec(0, 100, 3, 12'hABC, 12'hABC, 12'hABC, 1'b1, 100);
        set_vec(1,  10, 2, 12'h111, 12'h222, 12'h000, 1'b0,  68);
        set_vec(2,  69, 2, 12'h5A5, 12'hA5A, 12'h000, 1'b0,  69);
        set_vec(3,  68, 3, 12'hFFF, 12'h000, 12'h801, 1'b0,  68);
        set_vec(4,   0, 1, 12'h123, 12'h000, 12'h000, 1'b0,   0);
        smp_if.smp_rdy = 1'b1;

        // reset state
        #12;
        chk("rst_cs_n", {31'd0, ad_cs_n}, 32'd1);
        chk("rst_sclk", {31'd0, ad_sclk}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_vld", {31'd0, smp_if.smp_vld}, 32'd0);
        chk("rst_data", {20'd0, smp_if.smp_data}, 32'd0);
        chk("rst_ovr", {31'd0, smp_if.smp_ovr}, 32'd0);
        chk("rst_state", {30'd0, dbg_state}, 32'd0);
`ifdef AD_OVR_CNT_EN
        chk("rst_ovr_cnt", {16'd0, smp_if.ovr_cnt}, 32'd0);
`endif
        @(posedge clk_sys); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk_sys);

        // table-driven bursts
        for (int i = 0; i < 5; i++) begin
            clear_mon();
            cfg_period = 16'(vecs[i].period);
            cfg_num    = 16'(vecs[i].num);
            push_sample(vecs[i].d0, 1'b1);
            if (vecs[i].num > 1) push_sample(vecs[i].d1, 1'b1);
            if (vecs[i].num > 2) push_sample(vecs[i].d2, 1'b1);
            last = (vecs[i].num == 3) ? vecs[i].d2 : (vecs[i].num == 2) ? vecs[i].d1 : vecs[i].d0;
            pulse_start();
            chk("start_cs_n", {31'd0, ad_cs_n}, 32'd0);
            chk("start_busy", {31'd0, busy}, 32'd1);
            chk("start_sclk", {31'd0, ad_sclk}, 32'd0);
            if (vecs[i].restart) begin
                repeat (30) @(posedge clk_sys);
                #1 cmd_start = 1'b1;
                @(posedge clk_sys); #1 cmd_start = 1'b0;
            end
            wait_done(1000);
            repeat (5) @(posedge clk_sys);
            #1;
            chk("burst_falls", fall_q.size(), vecs[i].num);
            for (int k = 1; k < fall_q.size(); k++)
                chk("burst_gap", fall_q[k] - fall_q[k-1], vecs[i].gap);
            if (rise_q.size() > 0) chk("frame_len", rise_q[0] - fall_q[0], 64);
            chk("burst_done_cnt", done_cnt, 1);
            chk("burst_sb_empty", exp_q.size(), 0);
            chk("burst_busy_end", {31'd0, busy}, 32'd0);
            chk("burst_vld_end", {31'd0, smp_if.smp_vld}, 32'd0);
            chk("burst_last_data", {20'd0, smp_if.smp_data}, {20'd0, last});
            chk("burst_no_ovr", {31'd0, smp_if.smp_ovr}, 32'd0);
        end

        // overrun: downstream stalled across two results
        clear_mon();
        smp_if.smp_rdy = 1'b0;
        cfg_period = 16'd10;
        cfg_num    = 16'd2;
        push_sample(12'h111, 1'b0);
        push_sample(12'h222, 1'b0);
        pulse_start();
        wait_done(500);
        chk("ovr_data", {20'd0, smp_if.smp_data}, 32'h222);
        chk("ovr_vld", {31'd0, smp_if.smp_vld}, 32'd1);
        chk("ovr_flag", {31'd0, smp_if.smp_ovr}, 32'd1);
`ifdef AD_OVR_CNT_EN
        chk("ovr_cnt", {16'd0, smp_if.ovr_cnt}, 32'd1);
`endif
        exp_q.push_back(12'h222);
        @(posedge clk_sys); #1 smp_if.smp_rdy = 1'b1;
        @(posedge clk_sys); #1;
        chk("ovr_vld_drop", {31'd0, smp_if.smp_vld}, 32'd0);
        chk("ovr_sticky", {31'd0, smp_if.smp_ovr}, 32'd1);
        chk("ovr_sb_empty", exp_q.size(), 0);

        // continuous mode, stop 10 cycles into the third frame
        clear_mon();
        cfg_num = 16'd0;
        push_sample(12'h321, 1'b1);
        push_sample(12'h654, 1'b1);
        push_sample(12'h987, 1'b1);
        pulse_start();
        chk("cont_ovr_cleared", {31'd0, smp_if.smp_ovr}, 32'd0);
`ifdef AD_OVR_CNT_EN
        chk("cont_ovr_cnt_cleared", {16'd0, smp_if.ovr_cnt}, 32'd0);
`endif
        wait_falls(3, 400);
        repeat (9) @(posedge clk_sys);
        pulse_stop();
        chk("stop_frame_kept", {31'd0, ad_cs_n}, 32'd0);
        wait_done(300);
        repeat (80) @(posedge clk_sys);
        #1;
        chk("stop_falls", fall_q.size(), 3);
        if (fall_q.size() == 3 && rise_q.size() == 3)
            chk("stop_frame_len", rise_q[2] - fall_q[2], 64);
        else
            chk("stop_rise_count", rise_q.size(), 3);
        chk("stop_done_cnt", done_cnt, 1);
        chk("stop_sb_empty", exp_q.size(), 0);
        chk("stop_busy", {31'd0, busy}, 32'd0);

        // asynchronous reset in the middle of the second frame with a result pending
        clear_mon();
        smp_if.smp_rdy = 1'b0;
        push_sample(12'h0AA, 1'b0);
        push_sample(12'h055, 1'b0);
        pulse_start();
        wait_falls(2, 300);
        repeat (10) @(posedge clk_sys);
        #1;
        chk("pre_rst_vld", {31'd0, smp_if.smp_vld}, 32'd1);
        chk("pre_rst_cs_n", {31'd0, ad_cs_n}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cs_n", {31'd0, ad_cs_n}, 32'd1);
        chk("arst_sclk", {31'd0, ad_sclk}, 32'd1);
        chk("arst_vld", {31'd0, smp_if.smp_vld}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk_sys); #1 rst_n = 1'b1;
        smp_if.smp_rdy = 1'b1;
        adc_q.delete();

        // start and stop together, and start while disabled: both ignored
        clear_mon();
        cfg_num = 16'd1;
        @(posedge clk_sys); #1 begin cmd_start = 1'b1; cmd_stop = 1'b1; end
        @(posedge clk_sys); #1 begin cmd_start = 1'b0; cmd_stop = 1'b0; end
        chk("ss_cs_n", {31'd0, ad_cs_n}, 32'd1);
        chk("ss_busy", {31'd0, busy}, 32'd0);
        cfg_en = 1'b0;
        pulse_start();
        chk("dis_busy", {31'd0, busy}, 32'd0);
        cfg_en = 1'b1;
        repeat (10) @(posedge clk_sys);
        #1;
        chk("ss_falls", fall_q.size(), 0);
        chk("ss_done_cnt", done_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
